// File: rtl/button_press_encoder.sv
// Button front end for the memory game: synchronise, debounce, detect rising edges, emit indexed press events.
// Optional seed capture is enabled with `define BTN_SEED_CAPTURE_EN.
module button_press_encoder #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic       osc_clk,
   input  logic       reset_n,
   input  logic [3:0] button,
   input  logic       press_ready,
   output logic       press_valid,
   output logic [1:0] press_idx,
   output logic [3:0] btn_level,
   output logic       multi_press,
   output logic       overrun
`ifdef BTN_SEED_CAPTURE_EN
   ,
   output logic [7:0] seed
`endif
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [3:0]       sync1;
   logic [3:0]       sync2;
   logic [3:0]       level_d;
   logic [3:0]       rise;
   logic [CNT_W-1:0] cnt [4];
   logic [1:0]       low_idx;
   logic             multi;
   logic             load;

   // Two-flop synchroniser for the asynchronous raw buttons.
   always_ff @(posedge osc_clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= button;
         sync2 <= sync1;
      end
   end

   // A level change is accepted only after DEBOUNCE_CYCLES consecutive mismatching samples.
   always_ff @(posedge osc_clk or negedge reset_n) begin
      if (!reset_n) begin
         btn_level <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == btn_level[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               btn_level[i] <= sync2[i];
               cnt[i]       <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge osc_clk or negedge reset_n) begin
      if (!reset_n) begin
         level_d <= '0;
      end else begin
         level_d <= btn_level;
      end
   end

   assign rise = btn_level & ~level_d;
   assign load = (rise != 4'b0000) && (!press_valid || press_ready);

   always_comb begin
      low_idx = 2'd0;
      multi   = ($countones(rise) > 1);
      if (rise[0]) begin
         low_idx = 2'd0;
      end else if (rise[1]) begin
         low_idx = 2'd1;
      end else if (rise[2]) begin
         low_idx = 2'd2;
      end else if (rise[3]) begin
         low_idx = 2'd3;
      end
   end

   // Single-entry event register; a rise that finds it occupied and stalled is dropped.
   always_ff @(posedge osc_clk or negedge reset_n) begin
      if (!reset_n) begin
         press_valid <= 1'b0;
         press_idx   <= 2'd0;
         multi_press <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         multi_press <= multi;
         overrun     <= 1'b0;
         if (load) begin
            press_valid <= 1'b1;
            press_idx   <= low_idx;
         end else if (rise != 4'b0000) begin
            overrun <= 1'b1;
         end else if (press_ready) begin
            press_valid <= 1'b0;
         end
      end
   end

`ifdef BTN_SEED_CAPTURE_EN
   logic [7:0] free_cnt;

   // Seed is the free-running count at the moment a press is accepted.
   always_ff @(posedge osc_clk or negedge reset_n) begin
      if (!reset_n) begin
         free_cnt <= 8'd0;
         seed     <= 8'd0;
      end else begin
         free_cnt <= free_cnt + 8'd1;
         if (load) begin
            seed <= free_cnt;
         end
      end
   end
`endif

endmodule

// File: doc/button_press_encoder.md
Name: button_press_encoder

Overview:
- Upstream front end of the LED/button memory game.
- Synchronises and debounces the four raw push-buttons.
- Converts each clean press into a single indexed press event, delivered to the game controller over a valid/ready handshake.
- Flags presses that are ambiguous (simultaneous) or lost (consumer not ready).

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a level change (10 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20, width of each per-button debounce counter.

Ports:
- osc_clk  input  1  system clock.
- reset_n  input  1  reset, asynchronous assert, active-low.
- button  input  4  raw buttons, active-high, asynchronous to osc_clk.
- press_ready  input  1  consumer can accept an event this cycle.
- press_valid  output  1  press event pending.
- press_idx  output  2  index of the pressed button; valid while press_valid=1.
- btn_level  output  4  debounced button levels.
- multi_press  output  1  one-cycle pulse: two or more buttons became pressed on the same cycle.
- overrun  output  1  one-cycle pulse: a press event was dropped.
- seed  output  8  only present with BTN_SEED_CAPTURE_EN (see below).

Behaviour:
- Reset (reset_n=0, async) clears:
  - both synchroniser stages, all counters and btn_level to 0;
  - press_valid, press_idx, multi_press and overrun to 0.
- Synchroniser: two flops per bit (s1, s2); s2 drives the debounce logic.
- Per-button debounce, every cycle:
  - if s2 == btn_level[i], cnt[i] <= 0;
  - otherwise, if cnt[i] == DEBOUNCE_CYCLES-1, then btn_level[i] <= s2 and cnt[i] <= 0;
  - otherwise cnt[i] <= cnt[i]+1.
- Debounce consequences:
  - a level change needs DEBOUNCE_CYCLES consecutive mismatch cycles;
  - any glitch restarts the count;
  - release is debounced identically.
- Rise detect: rise[i] = btn_level[i] & ~btn_level_d[i], where btn_level_d is btn_level delayed one cycle. Releases generate no event.
- Latency: raw button held high, first sampled at edge E0:
  - btn_level rises at edge E0+DEBOUNCE_CYCLES+1;
  - press_valid rises at edge E0+DEBOUNCE_CYCLES+2.
- Event register (single entry):
  - Any rise, and the register is empty or press_ready=1 (handshake completes this cycle): load press_valid=1 and press_idx = lowest index with rise set.
  - More than one rise bit set in the same cycle: multi_press=1 for one cycle. The event is still issued with the lowest index.
  - Rise while press_valid=1 and press_ready=0: the new press is dropped, overrun=1 for one cycle, and the held event is unchanged.
  - press_valid=1 and press_ready=1 with no new rise: press_valid <= 0 on the next edge.
  - press_idx holds its value while press_valid=1 and press_ready=0.
- Button held indefinitely: exactly one event. The next event requires a debounced release, then a debounced press.
- Reset mid-debounce: the counter is lost. A button held through reset release is treated as a fresh press and produces an event after full latency.
- Counter width rule: cnt compares at DEBOUNCE_CYCLES-1 and never wraps.

Optional Feature:
- Macro: BTN_SEED_CAPTURE_EN.
- Defined:
  - an 8-bit free-running counter increments every cycle from reset (reset value 0, wraps 255->0);
  - the seed port exists;
  - seed latches the free-running counter value on each cycle an event is loaded into the event register, giving the game a player-timing-derived random seed;
  - seed resets to 0.
- Undefined: no free-running counter and no seed port. All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4):
- Button[2] raised, first sampled at E0, held 40 cycles, press_ready=1 -> btn_level[2]=1 at E0+5; press_valid=1, press_idx=2 at E0+6 for one cycle; no further event while held.
- Button[1] pulses high 3 cycles, low 1 cycle, high 3 cycles -> btn_level stays 0; no press_valid.
- Buttons [3] and [0] raised on the same cycle -> press_idx=0, multi_press pulses once, single event.
- press_ready=0; press button 1, release, then press button 3 -> press_valid=1 with press_idx=1 held; overrun pulses at button 3's rise; after press_ready=1, one handshake, then press_valid=0.
- Button[0] held, reset_n pulsed low mid-debounce (cnt=2) then released while button still held -> all outputs 0 during reset; event press_idx=0 issued 6 edges after reset release.
- With BTN_SEED_CAPTURE_EN: press accepted when free-running counter = 0x2A -> seed=0x2A on the following cycle; seed unchanged until next accepted press.
